mac_rx: RTL and testbench

- Gigabit-style RGMII receive MAC front end.
- Captures 4-bit DDR nibbles from the PHY, strips preamble and SFD, and stores each frame (DA through FCS) in one of two ping-pong byte buffers.
- Hands complete frames to the host side through a received/ack/read-stream handshake.
- Sits between the PHY pins and the packet-processing logic; performs no CRC check or address filtering.

---
 rtl/mac_rx.sv | 186 ++++++++++++++++++
 tb/tb_mac_rx.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_rx.sv
// RGMII receive MAC front end: DDR nibble capture, preamble/SFD stripping,
// two ping-pong frame buffers and a host-side received/ack/stream-read port.
module mac_rx #(
  parameter int MAX_FRAME_BYTES = 2048,
  parameter int ADDR_W          = 11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       phy_rx_clk,
  input  logic       phy_rx_ctl,
  input  logic       config_ready,
  input  logic [3:0] phy_rxd,
  input  logic       frame_received_ack,
  input  logic       read_en,
  output logic       frame_received,
  output logic [7:0] mac_rx_data_out,
  output logic       read_complete
);
  // Length counters carry one extra bit so a completely full buffer is representable.
  localparam int               LEN_W   = ADDR_W + 1;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_FRAME_BYTES);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2,
    DROP     = 2'd3
  } state_e;

  logic unused_rx_clk;
  assign unused_rx_clk = phy_rx_clk;

  logic [3:0] lo_q, hi_q;
  logic       ctl_q;
  logic [7:0] rx_byte;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lo_q  <= '0;
      ctl_q <= 1'b0;
    end else begin
      lo_q  <= phy_rxd;
      ctl_q <= phy_rx_ctl;
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) hi_q <= '0;
    else     hi_q <= phy_rxd;
  end

  assign rx_byte = {hi_q, lo_q};

  state_e           state, state_d;
  logic [LEN_W-1:0] fill_cnt_q, fill_cnt_d;
  logic [LEN_W-1:0] len_q [2];
  logic [1:0]       full_q, full_d;
  logic             wr_sel_q;
  logic             wr_en, commit;

  // Each assembled byte is consumed one rising edge after its low nibble was sampled.
  always_comb begin
    state_d    = state;
    fill_cnt_d = fill_cnt_q;
    wr_en      = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (ctl_q) begin
          fill_cnt_d = '0;
          state_d    = (config_ready && !full_q[wr_sel_q]) ? PREAMBLE : DROP;
        end
      end
      PREAMBLE: begin
        if (!ctl_q)                  state_d = IDLE;
        else if (rx_byte == 8'hD5)   state_d = DATA;
        else if (rx_byte != 8'h55)   state_d = DROP;
      end
      DATA: begin
        if (!ctl_q) begin
          commit  = (fill_cnt_q != '0);
          state_d = IDLE;
        end else if (fill_cnt_q == MAX_LEN) begin
          state_d = DROP;
        end else begin
          wr_en      = 1'b1;
          fill_cnt_d = fill_cnt_q + LEN_W'(1);
        end
      end
      DROP: begin
        if (!ctl_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  logic             rd_sel_q, rd_sel_d;
  logic             busy_q, busy_d;
  logic             fr_q, fr_d;
  logic             rc_q, rc_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]       dout_q;
  logic             rd_fire, release_buf, last_byte;

  assign rd_fire   = busy_q && !rc_q && read_en;
  assign last_byte = ({1'b0, rd_ptr_q} == (len_q[rd_sel_q] - LEN_W'(1)));

  // A buffer stays selected (busy) until the host drops read_en after read_complete.
  always_comb begin
    rd_sel_d    = rd_sel_q;
    busy_d      = busy_q;
    fr_d        = fr_q;
    rc_d        = rc_q;
    rd_ptr_d    = rd_ptr_q;
    release_buf = 1'b0;
    if (fr_q && frame_received_ack) begin
      fr_d     = 1'b0;
      busy_d   = 1'b1;
      rd_ptr_d = '0;
    end else if (!busy_q && !fr_q && full_q[rd_sel_q]) begin
      fr_d = 1'b1;
    end
    if (busy_q && rc_q && !read_en) begin
      rc_d   = 1'b0;
      busy_d = 1'b0;
    end
    if (rd_fire) begin
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      if (last_byte) begin
        rc_d        = 1'b1;
        release_buf = 1'b1;
        rd_sel_d    = ~rd_sel_q;
      end
    end
  end

  always_comb begin
    full_d = full_q;
    if (release_buf) full_d[rd_sel_q] = 1'b0;
    if (commit)      full_d[wr_sel_q] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      fill_cnt_q <= '0;
      len_q[0]   <= '0;
      len_q[1]   <= '0;
      full_q     <= '0;
      wr_sel_q   <= 1'b0;
      rd_sel_q   <= 1'b0;
      busy_q     <= 1'b0;
      fr_q       <= 1'b0;
      rc_q       <= 1'b0;
      rd_ptr_q   <= '0;
    end else begin
      state      <= state_d;
      fill_cnt_q <= fill_cnt_d;
      full_q     <= full_d;
      rd_sel_q   <= rd_sel_d;
      busy_q     <= busy_d;
      fr_q       <= fr_d;
      rc_q       <= rc_d;
      rd_ptr_q   <= rd_ptr_d;
      if (commit) begin
        len_q[wr_sel_q] <= fill_cnt_q;
        wr_sel_q        <= ~wr_sel_q;
      end
    end
  end

  logic [7:0] mem [2][MAX_FRAME_BYTES];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_sel_q][fill_cnt_q[ADDR_W-1:0]] <= rx_byte;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          dout_q <= 8'h00;
    else if (rd_fire) dout_q <= mem[rd_sel_q][rd_ptr_q];
  end

  assign frame_received  = fr_q;
  assign read_complete   = rc_q;
  assign mac_rx_data_out = dout_q;
endmodule

// File: tb/tb_mac_rx.sv
// Self-checking bench for mac_rx: drives RGMII DDR nibbles, keeps expected
// frame bytes in a scoreboard queue and compares them against the host read stream.
module tb_mac_rx;
  logic       clk = 1'b0;
  logic       rst;
  logic       phy_rx_clk;
  logic       phy_rx_ctl;
  logic       config_ready;
  logic [3:0] phy_rxd;
  logic       frame_received_ack;
  logic       read_en;
  logic       frame_received;
  logic [7:0] mac_rx_data_out;
  logic       read_complete;

  int         checks = 0;
  int         passes = 0;
  logic [7:0] exp_q[$];
  int         exp_len_q[$];
  logic [7:0] frm[$];

  mac_rx dut (
    .clk                (clk),
    .rst                (rst),
    .phy_rx_clk         (phy_rx_clk),
    .phy_rx_ctl         (phy_rx_ctl),
    .config_ready       (config_ready),
    .phy_rxd            (phy_rxd),
    .frame_received_ack (frame_received_ack),
    .read_en            (read_en),
    .frame_received     (frame_received),
    .mac_rx_data_out    (mac_rx_data_out),
    .read_complete      (read_complete)
  );

  always #5 clk = ~clk;
  assign phy_rx_clk = clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Low nibble + ctl are set up before the rising edge, high nibble before the falling edge.
  task automatic drive_byte(input logic [7:0] b, input logic c);
    @(negedge clk);
    #2 phy_rxd = b[3:0];
    phy_rx_ctl = c;
    @(posedge clk);
    #2 phy_rxd = b[7:4];
  endtask

  task automatic idle(input int n);
    repeat (n) drive_byte(8'h00, 1'b0);
  endtask

  task automatic send_frame(input bit store);
    if (store) begin
      foreach (frm[i]) exp_q.push_back(frm[i]);
      exp_len_q.push_back(frm.size());
    end
    repeat (7) drive_byte(8'h55, 1'b1);
    drive_byte(8'hD5, 1'b1);
    foreach (frm[i]) drive_byte(frm[i], 1'b1);
    idle(3);
  endtask

  task automatic build_frame1();
    logic [7:0] b [30] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
                           8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC,
                           8'h08, 8'h00,
                           8'hF1, 8'h01, 8'hF1, 8'h02, 8'hF1, 8'h03,
                           8'hF1, 8'h04, 8'hF1, 8'h05, 8'hF1, 8'h06,
                           8'h2b, 8'hb4, 8'hc3, 8'hff};
    frm.delete();
    foreach (b[i]) frm.push_back(b[i]);
  endtask

  task automatic build_frame2();
    logic [7:0] h [14] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF,
                           8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                           8'h08, 8'h06};
    frm.delete();
    foreach (h[i]) frm.push_back(h[i]);
    repeat (16) frm.push_back(8'($urandom_range(0, 255)));
    frm.push_back(8'h87);
    frm.push_back(8'h65);
    frm.push_back(8'h43);
    frm.push_back(8'h21);
  endtask

  task automatic build_random(input int n);
    frm.delete();
    repeat (n) frm.push_back(8'($urandom_range(1, 255)));
  endtask

  task automatic wait_frame_received(input string tag);
    int waited = 0;
    while (frame_received !== 1'b1 && waited < 300) begin
      @(posedge clk);
      #1;
      waited++;
    end
    checks++;
    if (frame_received !== 1'b1)
      $display("FAIL %s_frame_received: got %b expected 1 within 300 cycles", tag, frame_received);
    else passes++;
  endtask

  task automatic read_frame(input string tag, input int min_gap);
    int         n;
    logic [7:0] exp_b;
    exp_b = 8'h00;
    if (exp_len_q.size() == 0) begin
      checks++;
      $display("FAIL %s_queue: no expected frame queued", tag);
      return;
    end
    n = exp_len_q.pop_front();
    wait_frame_received(tag);
    frame_received_ack = 1'b1;
    @(posedge clk);
    #1 frame_received_ack = 1'b0;
    checks++;
    if (frame_received !== 1'b0)
      $display("FAIL %s_ack_clear: got %b expected 0", tag, frame_received);
    else passes++;
    for (int i = 0; i < n; i++) begin
      read_en = 1'b0;
      repeat ($urandom_range(min_gap, 2)) begin
        @(posedge clk);
        #1;
      end
      read_en = 1'b1;
      @(posedge clk);
      #1;
      exp_b = exp_q.pop_front();
      checks++;
      if (mac_rx_data_out !== exp_b)
        $display("FAIL %s_byte%0d: got %h expected %h", tag, i, mac_rx_data_out, exp_b);
      else passes++;
      checks++;
      if (read_complete !== (i == n - 1))
        $display("FAIL %s_rc%0d: got %b expected %b", tag, i, read_complete, (i == n - 1));
      else passes++;
      checks++;
      if (frame_received !== 1'b0)
        $display("FAIL %s_fr_during_read%0d: got %b expected 0", tag, i, frame_received);
      else passes++;
    end
    read_en = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (read_complete !== 1'b0)
      $display("FAIL %s_rc_clear: got %b expected 0", tag, read_complete);
    else passes++;
    checks++;
    if (mac_rx_data_out !== exp_b)
      $display("FAIL %s_dout_hold: got %h expected %h", tag, mac_rx_data_out, exp_b);
    else passes++;
    checks++;
    if (frame_received !== 1'b0)
      $display("FAIL %s_fr_after_read: got %b expected 0", tag, frame_received);
    else passes++;
  endtask

  task automatic check_idle_quiet(input string tag);
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (frame_received !== 1'b0)
      $display("FAIL %s_no_frame: got %b expected 0", tag, frame_received);
    else passes++;
    checks++;
    if (dut.state !== 2'd0)
      $display("FAIL %s_state_idle: got %0d expected 0", tag, dut.state);
    else passes++;
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if (frame_received !== 1'b0)
      $display("FAIL %s_fr: got %b expected 0", tag, frame_received);
    else passes++;
    checks++;
    if (read_complete !== 1'b0)
      $display("FAIL %s_rc: got %b expected 0", tag, read_complete);
    else passes++;
    checks++;
    if (mac_rx_data_out !== 8'h00)
      $display("FAIL %s_dout: got %h expected 00", tag, mac_rx_data_out);
    else passes++;
    checks++;
    if (dut.state !== 2'd0)
      $display("FAIL %s_state: got %0d expected 0", tag, dut.state);
    else passes++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_pingpong();
    build_frame1();
    send_frame(1'b1);
    build_frame2();
    fork
      send_frame(1'b1);
      read_frame("f1", 1);
    join
    read_frame("f2", 0);
  endtask

  task automatic test_config_off();
    config_ready = 1'b0;
    drive_byte(8'h55, 1'b1);
    drive_byte(8'h55, 1'b1);
    checks++;
    if (dut.state !== 2'd3)
      $display("FAIL cfg_off_drop: got %0d expected 3", dut.state);
    else passes++;
    repeat (5) drive_byte(8'h55, 1'b1);
    drive_byte(8'hD5, 1'b1);
    build_frame1();
    foreach (frm[i]) drive_byte(frm[i], 1'b1);
    idle(3);
    check_idle_quiet("cfg_off");
    config_ready = 1'b1;
  endtask

  task automatic test_bad_preamble();
    drive_byte(8'h55, 1'b1);
    drive_byte(8'h55, 1'b1);
    drive_byte(8'h12, 1'b1);
    drive_byte(8'hD5, 1'b1);
    checks++;
    if (dut.state !== 2'd3)
      $display("FAIL bad_pre_drop: got %0d expected 3", dut.state);
    else passes++;
    build_random(20);
    foreach (frm[i]) drive_byte(frm[i], 1'b1);
    idle(3);
    check_idle_quiet("bad_pre");
  endtask

  task automatic test_back_to_back();
    build_random(24);
    send_frame(1'b1);
    build_random(50);
    send_frame(1'b1);
    build_random(20);
    send_frame(1'b0);
    read_frame("bb1", 0);
    read_frame("bb2", 0);
    check_idle_quiet("bb3_dropped");
  endtask

  task automatic test_reset_mid();
    build_random(16);
    send_frame(1'b0);
    wait_frame_received("rmid_pending");
    frame_received_ack = 1'b1;
    @(posedge clk);
    #1 frame_received_ack = 1'b0;
    read_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 read_en = 1'b0;
    repeat (7) drive_byte(8'h55, 1'b1);
    drive_byte(8'hD5, 1'b1);
    repeat (5) drive_byte(8'($urandom_range(1, 255)), 1'b1);
    checks++;
    if (dut.state !== 2'd2)
      $display("FAIL rmid_in_data: got %0d expected 2", dut.state);
    else passes++;
    rst = 1'b1;
    phy_rx_ctl = 1'b0;
    #1;
    check_reset_values("rmid");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(3);
    build_random(25);
    send_frame(1'b1);
    read_frame("post_rst", 0);
    check_idle_quiet("post_rst");
  endtask

  initial begin
    rst                = 1'b1;
    phy_rx_ctl         = 1'b0;
    phy_rxd            = 4'h0;
    config_ready       = 1'b1;
    frame_received_ack = 1'b0;
    read_en            = 1'b0;
    test_reset();
    test_pingpong();
    test_config_off();
    test_bad_preamble();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
